// File: rtl/data_sram_if.sv
// CPU data-SRAM request/response bundle between the EX/MEM stages and the SRAM responder.
// The master drives requests; the slave returns read data, stall and error status.
interface data_sram_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stallreq;
    logic        addr_err;

    modport master (
        output en, wen, addr, wdata,
        input  rdata, stallreq, addr_err
    );

    modport slave (
        input  en, wen, addr, wdata,
        output rdata, stallreq, addr_err
    );
endinterface

// File: rtl/data_sram_rsp.sv
// Data-SRAM responder: word-addressed memory with byte-lane stores and
// registered loads delayed by WAIT_CYCLES stall cycles.
//
// state | meaning
// IDLE  | ready to accept a request this cycle
// BUSY  | read accepted, counting down wait states before loading rdata
module data_sram_rsp #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         resetn,
    data_sram_if.slave   bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] N_WAIT = 3'(WAIT_CYCLES);

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    state_t            state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx;
    logic              in_range;
    logic              is_read;
    logic              accept;
    logic              unused_addr_lsb;

    assign idx             = bus.addr[ADDR_W+1:2];
    assign in_range        = (bus.addr[31:ADDR_W+2] == '0);
    assign is_read         = (bus.wen == 4'b0000);
    assign accept          = (state == IDLE) && bus.en;
    assign unused_addr_lsb = ^bus.addr[1:0];

    // Combinational so the stall takes effect in the same cycle as the request.
    assign bus.stallreq = (accept && is_read && in_range && (N_WAIT != 3'd0))
                        || ((state == BUSY) && (cnt != 3'd1));

    // Memory is deliberately left out of reset; stores are gated by resetn instead.
    always_ff @(posedge clk) begin
        if (resetn && accept && !is_read && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wen[i]) begin
                    mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            idx_q        <= '0;
            bus.rdata    <= 32'h0;
            bus.addr_err <= 1'b0;
        end else begin
            bus.addr_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        if (!in_range) begin
                            bus.addr_err <= 1'b1;
                            if (is_read) begin
                                bus.rdata <= 32'h0;
                            end
                        end else if (is_read) begin
                            if (N_WAIT == 3'd0) begin
                                bus.rdata <= mem[idx];
                            end else begin
                                state <= BUSY;
                                cnt   <= N_WAIT;
                                idx_q <= idx;
                            end
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        bus.rdata <= mem[idx_q];
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_sram_rsp.sv
// Directed bench for data_sram_rsp: one instance with no wait states, one with three.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after.
module tb_data_sram_rsp;
    logic clk;
    logic resetn0;
    logic resetn3;
    int   n_checks;
    int   n_errors;
    int   n_stall;

    data_sram_if bus0 ();
    data_sram_if bus3 ();

    data_sram_rsp #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .clk    (clk),
        .resetn (resetn0),
        .bus    (bus0.slave)
    );

    data_sram_rsp #(.ADDR_W(12), .WAIT_CYCLES(3)) dut3 (
        .clk    (clk),
        .resetn (resetn3),
        .bus    (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input bit sel, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            bus3.en = en; bus3.wen = wen; bus3.addr = addr; bus3.wdata = wdata;
        end else begin
            bus0.en = en; bus0.wen = wen; bus0.addr = addr; bus0.wdata = wdata;
        end
    endtask

    // Holds a read on dut3 until stallreq drops; leaves the bench in the first non-stalled cycle.
    task automatic count_stall();
        n_stall = 0;
        while (bus3.stallreq === 1'b1 && n_stall < 20) begin
            n_stall++;
            tick();
            settle();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn0  = 1'b1;
        resetn3  = 1'b1;
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);

        // Asynchronous reset asserted before any clock edge
        #3;
        resetn0 = 1'b0;
        resetn3 = 1'b0;
        #1;
        chk("rst0_rdata",    bus0.rdata,    32'h0);
        chk("rst0_stall",    32'(bus0.stallreq), 32'h0);
        chk("rst0_addr_err", 32'(bus0.addr_err), 32'h0);
        chk("rst3_rdata",    bus3.rdata,    32'h0);
        chk("rst3_stall",    32'(bus3.stallreq), 32'h0);
        chk("rst3_addr_err", 32'(bus3.addr_err), 32'h0);
        tick();
        resetn0 = 1'b1;
        resetn3 = 1'b1;

        // Store word then load, no wait states
        tick();
        drive(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        settle();
        chk("wr_stall", 32'(bus0.stallreq), 32'h0);
        tick();
        drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
        settle();
        chk("rd_stall",       32'(bus0.stallreq), 32'h0);
        chk("wr_rdata_held",  bus0.rdata, 32'h0);
        tick();
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("rd_word", bus0.rdata, 32'hDEADBEEF);

        // Byte-lane merges, read-after-write in the following cycle
        tick();
        drive(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
        tick();
        drive(0, 1'b1, 4'b0100, 32'h20, 32'h00AA0000);
        tick();
        drive(0, 1'b1, 4'h0, 32'h20, 32'h0);
        tick();
        drive(0, 1'b1, 4'b0011, 32'h22, 32'h00005566);
        settle();
        chk("merge_lane2", bus0.rdata, 32'h11AA3344);
        tick();
        drive(0, 1'b1, 4'h0, 32'h20, 32'h0);
        tick();
        drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
        settle();
        chk("merge_lane01", bus0.rdata, 32'h11AA5566);
        // Back-to-back reads accepted on consecutive edges
        tick();
        drive(0, 1'b1, 4'h0, 32'h20, 32'h0);
        settle();
        chk("b2b_first", bus0.rdata, 32'hDEADBEEF);
        tick();
        drive(0, 1'b1, 4'hF, 32'h0, 32'h0BADF00D);
        settle();
        chk("b2b_second", bus0.rdata, 32'h11AA5566);

        // Out-of-range read and write; index bits alias word 0
        tick();
        drive(0, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
        settle();
        chk("oor_rd_stall",   32'(bus0.stallreq), 32'h0);
        chk("oor_err_before", 32'(bus0.addr_err), 32'h0);
        tick();
        drive(0, 1'b1, 4'hF, 32'h0001_0000, 32'hFFFFFFFF);
        settle();
        chk("oor_rd_rdata", bus0.rdata, 32'h0);
        chk("oor_rd_err",   32'(bus0.addr_err), 32'h1);
        tick();
        drive(0, 1'b1, 4'h0, 32'h0, 32'h0);
        settle();
        chk("oor_wr_err",   32'(bus0.addr_err), 32'h1);
        chk("oor_wr_rdata", bus0.rdata, 32'h0);
        tick();
        drive(0, 1'b1, 4'h0, 32'h10, 32'h0);
        settle();
        chk("oor_word0",    bus0.rdata, 32'h0BADF00D);
        chk("oor_err_pulse", 32'(bus0.addr_err), 32'h0);
        tick();
        drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("oor_word4", bus0.rdata, 32'hDEADBEEF);

        // Wait states, N = 3, request held while stalled
        drive(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        settle();
        chk("w3_wr_stall", 32'(bus3.stallreq), 32'h0);
        tick();
        drive(1, 1'b1, 4'h0, 32'h10, 32'h0);
        settle();
        count_stall();
        chk("w3_stall_cycles", 32'(n_stall), 32'd3);
        chk("w3_rdata_t3",     bus3.rdata, 32'h0);
        tick();
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("w3_rdata_t4", bus3.rdata, 32'hDEADBEEF);
        chk("w3_stall_t4", 32'(bus3.stallreq), 32'h0);
        tick();
        chk("w3_rdata_hold", bus3.rdata, 32'hDEADBEEF);

        // Out-of-range read with wait states configured: no stall
        drive(1, 1'b1, 4'h0, 32'h0001_0000, 32'h0);
        settle();
        chk("w3_oor_stall", 32'(bus3.stallreq), 32'h0);
        tick();
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("w3_oor_rdata", bus3.rdata, 32'h0);
        chk("w3_oor_err",   32'(bus3.addr_err), 32'h1);

        // Reset during BUSY discards the pending read
        tick();
        drive(1, 1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        chk("rb_busy_stall", 32'(bus3.stallreq), 32'h1);
        resetn3 = 1'b0;
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("rb_stall", 32'(bus3.stallreq), 32'h0);
        chk("rb_rdata", bus3.rdata, 32'h0);
        tick();
        tick();
        tick();
        resetn3 = 1'b1;
        tick();
        tick();
        chk("rb_rdata_after", bus3.rdata, 32'h0);
        chk("rb_stall_after", 32'(bus3.stallreq), 32'h0);
        drive(1, 1'b1, 4'h0, 32'h10, 32'h0);
        settle();
        count_stall();
        chk("rb_stall_cycles", 32'(n_stall), 32'd3);
        tick();
        drive(1, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("rb_reread", bus3.rdata, 32'hDEADBEEF);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
